// File: rtl/relay_rx_framer_if.sv
// Signal bundle between the relay receive framer and its surroundings.
// The master side drives mode, relay and ARM data; the slave side (the framer) drives the modulation outputs.
interface relay_rx_framer_if;
    logic [2:0] mode;
    logic       relay_in;
    logic       ssp_dout;
    logic [2:0] mod_type;
    logic       data_out;
    logic       din_mask;
    logic       bit_strobe;
    logic       frame_active;

    modport master (
        output mode, relay_in, ssp_dout,
        input  mod_type, data_out, din_mask, bit_strobe, frame_active
    );

    modport slave (
        input  mode, relay_in, ssp_dout,
        output mod_type, data_out, din_mask, bit_strobe, frame_active
    );
endinterface

// File: rtl/relay_rx_framer.sv
// Relay receive framer: samples the relay bit stream once per 16 clocks and detects ISO14443A
// frame start/end patterns to select the modulation type for hi_iso14443a in fake reader/tag modes.
module relay_rx_framer #(
    parameter logic [3:0] DIV_PHASE = 4'd8,
    parameter logic [7:0] TIMEOUT   = 8'd255
) (
    input logic              ck_1356meg,
    input logic              nrst,
    relay_rx_framer_if.slave bus
);

    localparam logic [2:0] MODE_READER  = 3'b101;
    localparam logic [2:0] MODE_TAG     = 3'b110;
    localparam logic [2:0] RMOD_RD_TX   = 3'b010;
    localparam logic [2:0] RMOD_RD_LSN  = 3'b011;
    localparam logic [2:0] RMOD_TAG_TX  = 3'b100;
    localparam logic [2:0] RMOD_TAG_LSN = 3'b001;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [2:0] listen_mod(input logic [2:0] m);
        return (m == MODE_READER) ? RMOD_RD_LSN : RMOD_TAG_LSN;
    endfunction

    logic        sync1_r;
    logic        relay_sync_r;
    logic [3:0]  div_cnt_r;
    logic [2:0]  prev_mode_r;
    logic [23:0] shift_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  tmo_r;
    logic [2:0]  rmod_r;
    state_t      state_r;

    logic        relay_s;
    logic        strobe_s;
    logic        mode_chg_s;
    logic [23:0] shift_post_s;
    logic [2:0]  bit_post_s;
    logic        start_s;
    logic        end_s;
    logic        timeout_s;

    logic [23:0] shift_nxt_s;
    logic [2:0]  bit_cnt_nxt_s;
    logic [7:0]  tmo_nxt_s;
    logic [2:0]  rmod_nxt_s;
    state_t      state_nxt_s;

    // Synchronizer, free-running bit divider and mode history
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            sync1_r      <= 1'b0;
            relay_sync_r <= 1'b0;
            div_cnt_r    <= 4'd0;
            prev_mode_r  <= 3'd0;
        end else begin
            sync1_r      <= bus.relay_in;
            relay_sync_r <= sync1_r;
            div_cnt_r    <= div_cnt_r + 4'd1;
            prev_mode_r  <= bus.mode;
        end
    end

    // Strobe timing and pattern matching on the post-shift buffer
    always_comb begin
        relay_s      = (bus.mode == MODE_READER) || (bus.mode == MODE_TAG);
        strobe_s     = relay_s && (div_cnt_r == DIV_PHASE);
        mode_chg_s   = relay_s && (bus.mode != prev_mode_r);
        shift_post_s = {shift_r[22:0], relay_sync_r};
        bit_post_s   = bit_cnt_r + 3'd1;
        timeout_s    = (state_r == ST_ACTIVE) && (tmo_r == TIMEOUT);
        start_s      = 1'b0;
        end_s        = 1'b0;
        case (bus.mode)
            MODE_READER: start_s = (shift_post_s == 24'h0000C0);
            MODE_TAG:    start_s = (shift_post_s == 24'h0000F0);
            default:     start_s = 1'b0;
        endcase
        if ((state_r == ST_ACTIVE) && (bit_post_s == 3'd0)) begin
            case (bus.mode)
                MODE_READER: end_s = (shift_post_s[23:8] == 16'h0000) ||
                                     (shift_post_s[23:8] == 16'hC000);
                MODE_TAG:    end_s = (shift_post_s[15:8] == 8'h00);
                default:     end_s = 1'b0;
            endcase
        end else begin
            end_s = 1'b0;
        end
    end

    // Next-state: start beats end, which beats timeout; mode changes resynchronise without detecting
    always_comb begin
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        tmo_nxt_s     = tmo_r;
        rmod_nxt_s    = rmod_r;
        state_nxt_s   = state_r;
        if (!relay_s) begin
            shift_nxt_s   = 24'd0;
            bit_cnt_nxt_s = 3'd0;
            tmo_nxt_s     = 8'd0;
            rmod_nxt_s    = 3'd0;
            state_nxt_s   = ST_IDLE;
        end else if (mode_chg_s) begin
            shift_nxt_s   = 24'd0;
            bit_cnt_nxt_s = 3'd0;
            tmo_nxt_s     = 8'd0;
            rmod_nxt_s    = listen_mod(bus.mode);
            state_nxt_s   = ST_IDLE;
        end else if (strobe_s) begin
            shift_nxt_s   = shift_post_s;
            bit_cnt_nxt_s = bit_post_s;
            if ((state_r == ST_ACTIVE) && (tmo_r != 8'hFF)) begin
                tmo_nxt_s = tmo_r + 8'd1;
            end else begin
                tmo_nxt_s = tmo_r;
            end
            if (start_s) begin
                state_nxt_s   = ST_ACTIVE;
                rmod_nxt_s    = (bus.mode == MODE_READER) ? RMOD_RD_TX : RMOD_TAG_TX;
                bit_cnt_nxt_s = 3'd0;
                tmo_nxt_s     = 8'd0;
            end else if (end_s || timeout_s) begin
                state_nxt_s = ST_IDLE;
                rmod_nxt_s  = listen_mod(bus.mode);
            end else begin
                state_nxt_s = state_r;
                rmod_nxt_s  = rmod_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame state registers
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            shift_r   <= 24'd0;
            bit_cnt_r <= 3'd0;
            tmo_r     <= 8'd0;
            rmod_r    <= 3'd0;
            state_r   <= ST_IDLE;
        end else begin
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            tmo_r     <= tmo_nxt_s;
            rmod_r    <= rmod_nxt_s;
            state_r   <= state_nxt_s;
        end
    end

    // Outputs stay combinational so a mode switch reaches hi_iso14443a without delay
    always_comb begin
        bus.mod_type     = relay_s ? rmod_r : bus.mode;
        bus.data_out     = relay_s ? shift_r[7] : bus.ssp_dout;
        bus.din_mask     = (bus.mod_type == RMOD_RD_TX);
        bus.bit_strobe   = strobe_s;
        bus.frame_active = (state_r == ST_ACTIVE);
    end

endmodule
